// File: rtl/y_frame_capture.sv
// Purpose: frame-capture sink; maps the vsync/href/clken Y stream to linear frame-buffer writes and checks frame geometry.
// Latency: a pixel accepted at clock edge N is written (wr_en/wr_addr/wr_data/pix_x/pix_y) in the cycle after edge N.
// Backpressure: none; the frame buffer must take one write per cycle, and pixels outside the configured frame are dropped.
module y_frame_capture #(
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480,
   parameter int ADDR_W    = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              per_frame_vsync,
   input  logic              per_frame_href,
   input  logic              per_frame_clken,
   input  logic [7:0]        per_img_Y,
   input  logic              cap_start,
   input  logic              cap_continuous,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [10:0]       pix_x,
   output logic [10:0]       pix_y,
   output logic              busy,
   output logic              frame_done,
   output logic              err_hlen,
   output logic              err_vlen
);

   localparam logic [10:0]       LP_H      = 11'(IMG_HDISP);
   localparam logic [10:0]       LP_V      = 11'(IMG_VDISP);
   localparam logic [ADDR_W-1:0] LP_H_A    = ADDR_W'(IMG_HDISP);
   localparam logic [10:0]       LP_LN_MAX = 11'h7FF;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_VS = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_arm;

   logic              r_vs_d;
   logic              r_href_d;
   logic [10:0]       r_x;
   logic [10:0]       r_y;
   logic [10:0]       r_lines;
   logic              r_x_ovf;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_line_base;

   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [7:0]        r_wr_data;
   logic [10:0]       r_pix_x;
   logic [10:0]       r_pix_y;
   logic              r_err_hlen;
   logic              r_err_vlen;

   logic              w_in_cap;
   logic              w_vs_rise;
   logic              w_vs_fall;
   logic              w_href_fall;
   logic              w_line_end;
   logic              w_pix;
   logic              w_accept;
   logic              w_x_over;

   // Edge detection compares the live inputs with last cycle's copies.
   assign w_in_cap    = (r_state == S_CAPTURE);
   assign w_vs_rise   = per_frame_vsync & ~r_vs_d;
   assign w_vs_fall   = ~per_frame_vsync & r_vs_d;
   assign w_href_fall = ~per_frame_href & r_href_d;
   // A line still open when vsync drops is closed in the same cycle.
   assign w_line_end  = w_in_cap & (w_href_fall | (w_vs_fall & per_frame_href));
   assign w_pix       = w_in_cap & per_frame_vsync & per_frame_href & per_frame_clken;
   assign w_accept    = w_pix & (r_x < LP_H) & (r_y < LP_V);
   // Pixels past the line width on an in-frame row mark the line as too long.
   assign w_x_over    = w_pix & (r_x >= LP_H) & (r_y < LP_V);

   assign wr_en    = r_wr_en;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign pix_x    = r_pix_x;
   assign pix_y    = r_pix_y;
   assign err_hlen = r_err_hlen;
   assign err_vlen = r_err_vlen;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and status decode; cap_start only matters in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_arm       = 1'b0;
      busy        = 1'b0;
      frame_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cap_start) begin
               w_state_nxt = S_WAIT_VS;
               w_arm       = 1'b1;
            end
         end
         S_WAIT_VS: begin
            busy = 1'b1;
            if (w_vs_rise) begin
               w_state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            busy = 1'b1;
            if (w_vs_fall) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            frame_done  = 1'b1;
            w_state_nxt = cap_continuous ? S_WAIT_VS : S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Registered copies of vsync/href for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_d   <= 1'b0;
         r_href_d <= 1'b0;
      end else begin
         r_vs_d   <= per_frame_vsync;
         r_href_d <= per_frame_href;
      end
   end

   // Coordinate/address counters, write port and sticky geometry errors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x         <= '0;
         r_y         <= '0;
         r_lines     <= '0;
         r_x_ovf     <= 1'b0;
         r_addr      <= '0;
         r_line_base <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_pix_x     <= '0;
         r_pix_y     <= '0;
         r_err_hlen  <= 1'b0;
         r_err_vlen  <= 1'b0;
      end else begin
         r_wr_en <= w_accept;
         if (w_accept) begin
            r_wr_addr <= r_addr;
            r_wr_data <= per_img_Y;
            r_pix_x   <= r_x;
            r_pix_y   <= r_y;
            r_x       <= r_x + 11'd1;
            r_addr    <= r_addr + ADDR_W'(1);
         end
         if (w_x_over) begin
            r_x_ovf <= 1'b1;
         end
         // Line base always steps a full line so a short line never shifts later rows.
         if (w_line_end) begin
            if ((r_x != LP_H) || r_x_ovf) begin
               r_err_hlen <= 1'b1;
            end
            if (r_lines != LP_LN_MAX) begin
               r_lines <= r_lines + 11'd1;
            end
            r_x     <= '0;
            r_x_ovf <= 1'b0;
            if (r_y < LP_V) begin
               r_y         <= r_y + 11'd1;
               r_line_base <= r_line_base + LP_H_A;
               r_addr      <= r_line_base + LP_H_A;
            end
         end
         if ((r_state == S_WAIT_VS) && w_vs_rise) begin
            r_x         <= '0;
            r_y         <= '0;
            r_lines     <= '0;
            r_x_ovf     <= 1'b0;
            r_addr      <= '0;
            r_line_base <= '0;
         end
         if ((r_state == S_DONE) && (r_lines != LP_V)) begin
            r_err_vlen <= 1'b1;
         end
         if (w_arm) begin
            r_err_hlen <= 1'b0;
            r_err_vlen <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_y_frame_capture.sv
// Purpose: scoreboard bench for y_frame_capture on a reduced 8x6 frame.
// Latency: expects each accepted pixel one cycle after its sampling edge.
// Backpressure: none; stimulus is self-timed so the run always ends.
module tb_y_frame_capture;

   localparam int H  = 8;
   localparam int V  = 6;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          vsync, href, clken;
   logic [7:0]    y_in;
   logic          cap_start, cap_cont;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic [10:0]   pix_x, pix_y;
   logic          busy, frame_done, err_hlen, err_vlen;

   always #5 clk = ~clk;

   y_frame_capture #(.IMG_HDISP(H), .IMG_VDISP(V), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
      .per_img_Y(y_in), .cap_start(cap_start), .cap_continuous(cap_cont),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .pix_x(pix_x), .pix_y(pix_y), .busy(busy), .frame_done(frame_done),
      .err_hlen(err_hlen), .err_vlen(err_vlen)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
      logic [10:0]   x;
      logic [10:0]   y;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_exp, mon_got;
   int  n_cmp    = 0;
   int  n_fail   = 0;
   int  exp_done = 0;
   int  obs_done = 0;

   // Monitor: every write the DUT presents is popped against the scoreboard.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && wr_en === 1'b1) begin
         mon_got = {wr_addr, wr_data, pix_x, pix_y};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr=%0d data=%0h x=%0d y=%0d, required no write",
                     wr_addr, wr_data, pix_x, pix_y);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               n_fail++;
               $display("FAIL write: got addr=%0d data=%0h x=%0d y=%0d, required addr=%0d data=%0h x=%0d y=%0d",
                        wr_addr, wr_data, pix_x, pix_y,
                        mon_exp.addr, mon_exp.data, mon_exp.x, mon_exp.y);
            end
         end
      end
      if (frame_done === 1'b1) obs_done++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic logic [7:0] pix(input logic [7:0] seed, input int r, input int c);
      return seed + 8'(r * 16) + 8'(c);
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic blank(input int n);
      vsync = 1'b0; href = 1'b0; clken = 1'b0;
      tick(n);
   endtask

   task automatic arm();
      cap_start = 1'b1;
      tick(1);
      cap_start = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"},      32'(wr_en),      0);
      check({tag, "_wr_addr"},    32'(wr_addr),    0);
      check({tag, "_wr_data"},    32'(wr_data),    0);
      check({tag, "_pix_x"},      32'(pix_x),      0);
      check({tag, "_pix_y"},      32'(pix_y),      0);
      check({tag, "_busy"},       32'(busy),       0);
      check({tag, "_frame_done"}, 32'(frame_done), 0);
      check({tag, "_err_hlen"},   32'(err_hlen),   0);
      check({tag, "_err_vlen"},   32'(err_vlen),   0);
   endtask

   // One frame: clken toggles every cycle during href. cap says whether the DUT
   // is expected to capture it from the start; odd_row carries odd_len pixels.
   task automatic send_frame(input int nlines, input bit cap_in, input int odd_row,
                             input int odd_len, input int arm_row, input int rst_row,
                             input int stop_row, input logic [7:0] seed);
      bit cap;
      int len;
      wr_t e;
      cap = cap_in;
      blank(3);
      vsync = 1'b1;
      tick(2);
      for (int r = 0; r < nlines; r++) begin
         if (r == arm_row) arm();
         if (r == stop_row) cap_cont = 1'b0;
         if (r == rst_row) begin
            check("pre_reset_err_hlen", 32'(err_hlen), 1);
            check("pre_reset_busy",     32'(busy),     1);
            rst_n = 1'b0;
            #1;
            check_all_zero("reset_mid");
            tick(1);
            rst_n = 1'b1;
            cap = 1'b0;
         end
         len = (r == odd_row) ? odd_len : H;
         for (int c = 0; c < len; c++) begin
            href = 1'b1; clken = 1'b1; y_in = pix(seed, r, c);
            if (cap && r < V && c < H) begin
               e.addr = AW'(r * H + c);
               e.data = pix(seed, r, c);
               e.x    = 11'(c);
               e.y    = 11'(r);
               exp_q.push_back(e);
            end
            tick(1);
            clken = 1'b0; y_in = 8'hEE;
            tick(1);
         end
         href = 1'b0;
         tick(3);
      end
      vsync = 1'b0;
      tick(1);
      if (cap) exp_done++;
   endtask

   task automatic after_frame(input string tag, input int hlen, input int vlen, input int bsy);
      blank(4);
      check({tag, "_done_cnt"}, 32'(obs_done),     32'(exp_done));
      check({tag, "_q_empty"},  32'(exp_q.size()), 0);
      check({tag, "_err_hlen"}, 32'(err_hlen),     32'(hlen));
      check({tag, "_err_vlen"}, 32'(err_vlen),     32'(vlen));
      check({tag, "_busy"},     32'(busy),         32'(bsy));
   endtask

   initial begin
      rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0; y_in = 8'h00;
      cap_start = 1'b0; cap_cont = 1'b0;
      tick(2);
      check_all_zero("reset_init");
      rst_n = 1'b1;
      tick(2);

      // Nominal frame.
      arm();
      check("armed_busy", 32'(busy), 1);
      send_frame(V, 1'b1, -1, 0, -1, -1, -1, 8'h10);
      after_frame("nominal", 0, 0, 0);

      // Short row 2 (7 pixels): row 3 still starts at addr 24.
      arm();
      send_frame(V, 1'b1, 2, H - 1, -1, -1, -1, 8'h40);
      after_frame("short", 1, 0, 0);

      // Long row 1 (9 pixels) and a 7th line: extras never written.
      arm();
      check("arm_clears_hlen", 32'(err_hlen), 0);
      send_frame(V + 1, 1'b1, 1, H + 1, -1, -1, -1, 8'h80);
      after_frame("long_extra", 1, 1, 0);

      // Arm during row 2: that frame is skipped, the next is captured whole.
      send_frame(V, 1'b0, -1, 0, 2, -1, -1, 8'h20);
      blank(2);
      check("midarm_busy", 32'(busy), 1);
      check("midarm_no_done", 32'(obs_done), 32'(exp_done));
      send_frame(V, 1'b1, -1, 0, -1, -1, -1, 8'h30);
      after_frame("midarm", 0, 0, 0);

      // Continuous: three frames, continuous dropped during the third.
      cap_cont = 1'b1;
      arm();
      send_frame(V, 1'b1, -1, 0, -1, -1, -1, 8'h51);
      after_frame("cont1", 0, 0, 1);
      send_frame(V, 1'b1, -1, 0, -1, -1, -1, 8'h62);
      after_frame("cont2", 0, 0, 1);
      send_frame(V, 1'b1, -1, 0, -1, -1, 2, 8'h73);
      after_frame("cont3", 0, 0, 0);
      send_frame(V, 1'b0, -1, 0, -1, -1, -1, 8'h84);
      after_frame("cont_idle", 0, 0, 0);

      // Reset at row 2 of a frame whose row 0 is short; then no capture without re-arm.
      arm();
      send_frame(V, 1'b1, 0, 5, -1, 2, -1, 8'h95);
      after_frame("reset", 0, 0, 0);
      send_frame(V, 1'b0, -1, 0, -1, -1, -1, 8'hA6);
      after_frame("post_reset", 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
